// File: rtl/gig_ethernet_pcs_pma_reset_seq_if.sv
// Status/control bundle between the transceiver reset sequencer (master) and the
// PLL/GT/PCS side it controls (slave).
interface gig_ethernet_pcs_pma_reset_seq_if;
  logic       pll_lock;
  logic       tx_resetdone;
  logic       rx_resetdone;
  logic       pll_reset;
  logic       gt_reset;
  logic       pcs_reset;
  logic       reset_done;
  logic [2:0] seq_state;
  logic [7:0] retry_count;

  modport master (
    input  pll_lock,
    input  tx_resetdone,
    input  rx_resetdone,
    output pll_reset,
    output gt_reset,
    output pcs_reset,
    output reset_done,
    output seq_state,
    output retry_count
  );

  modport slave (
    output pll_lock,
    output tx_resetdone,
    output rx_resetdone,
    input  pll_reset,
    input  gt_reset,
    input  pcs_reset,
    input  reset_done,
    input  seq_state,
    input  retry_count
  );
endinterface

// File: rtl/gig_ethernet_pcs_pma_reset_seq.sv
// Transceiver reset sequencer: PLL reset -> lock -> GT reset -> resetdone -> settle -> release PCS.
// Optional wait-state timeout with retry counting is enabled by defining RESET_SEQ_RETRY_EN.
module gig_ethernet_pcs_pma_reset_seq #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned GT_RST_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  gig_ethernet_pcs_pma_reset_seq_if.master bus
);

  localparam int unsigned CntW   = 24;
  localparam int unsigned RetryW = 8;

  localparam logic [CntW-1:0] PllLast    = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] GtLast     = CntW'(GT_RST_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    GT_RST    = 3'd2,
    WAIT_DONE = 3'd3,
    SETTLE    = 3'd4,
    DONE      = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic pll_reset_q, pll_reset_d;
  logic gt_reset_q, gt_reset_d;
  logic pcs_reset_q, pcs_reset_d;
  logic reset_done_q, reset_done_d;

  logic lock_c;
  logic rd_c;
  logic timeout_c;
  logic retry_inc_c;

  assign lock_c = bus.pll_lock;
  assign rd_c   = bus.tx_resetdone & bus.rx_resetdone;

  // Next state: loss of lock outranks loss of resetdone, which outranks normal progress.
  always_comb begin
    state_d     = state_q;
    retry_inc_c = 1'b0;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == PllLast) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_c) begin
          state_d = GT_RST;
        end else if (timeout_c) begin
          state_d     = PLL_RST;
          retry_inc_c = 1'b1;
        end
      end
      GT_RST: begin
        if (!lock_c)               state_d = PLL_RST;
        else if (cnt_q == GtLast)  state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!lock_c) begin
          state_d = PLL_RST;
        end else if (rd_c) begin
          state_d = SETTLE;
        end else if (timeout_c) begin
          state_d     = PLL_RST;
          retry_inc_c = 1'b1;
        end
      end
      SETTLE: begin
        if (!lock_c)                    state_d = PLL_RST;
        else if (!rd_c)                 state_d = GT_RST;
        else if (cnt_q == SettleLast)   state_d = DONE;
      end
      DONE: begin
        if (!lock_c)      state_d = PLL_RST;
        else if (!rd_c)   state_d = GT_RST;
      end
      default: state_d = PLL_RST;
    endcase
  end

  // Dwell counter restarts on every state change.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (state_d != state_q) cnt_d = '0;
  end

  // Output decode from the next state so registered outputs move with the state.
  always_comb begin
    pll_reset_d  = 1'b0;
    gt_reset_d   = 1'b0;
    pcs_reset_d  = 1'b1;
    reset_done_d = 1'b0;
    case (state_d)
      PLL_RST: begin
        pll_reset_d = 1'b1;
        gt_reset_d  = 1'b1;
      end
      WAIT_LOCK, GT_RST: begin
        gt_reset_d = 1'b1;
      end
      DONE: begin
        pcs_reset_d  = 1'b0;
        reset_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      pll_reset_q  <= 1'b1;
      gt_reset_q   <= 1'b1;
      pcs_reset_q  <= 1'b1;
      reset_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pll_reset_q  <= pll_reset_d;
      gt_reset_q   <= gt_reset_d;
      pcs_reset_q  <= pcs_reset_d;
      reset_done_q <= reset_done_d;
    end
  end

`ifdef RESET_SEQ_RETRY_EN
  localparam logic [CntW-1:0]   TmoLast  = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax = {RetryW{1'b1}};

  logic [CntW-1:0]   tmo_q, tmo_d;
  logic [RetryW-1:0] retry_q, retry_d;

  assign timeout_c = (tmo_q == TmoLast);

  // Timeout counter shares the state-entry clear; retry count saturates.
  always_comb begin
    tmo_d   = tmo_q + CntW'(1);
    retry_d = retry_q;
    if (state_d != state_q) tmo_d = '0;
    if (retry_inc_c && (retry_q != RetryMax)) retry_d = retry_q + RetryW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q   <= '0;
      retry_q <= '0;
    end else begin
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
    end
  end

  assign bus.retry_count = retry_q;
`else
  logic unused_timeout_cfg;

  assign timeout_c          = 1'b0;
  assign unused_timeout_cfg = ^{retry_inc_c, CntW'(TIMEOUT_CYCLES)};
  assign bus.retry_count    = '0;
`endif

  assign bus.pll_reset  = pll_reset_q;
  assign bus.gt_reset   = gt_reset_q;
  assign bus.pcs_reset  = pcs_reset_q;
  assign bus.reset_done = reset_done_q;
  assign bus.seq_state  = state_q;

endmodule
